controlador_botones: RTL

//  Shared-timebase debounce controller and event arbiter for a bank of push buttons.
//  - Synchronises NUM_BOTONES raw inputs.
//  - Debounces them against one shared sampling tick.
//  - Queues press events (debounced 0->1) and hands them one at a time to the consumer FSM.
//  - Uses a valid/ready handshake with round-robin fairness.
//  - Replaces per-button free-running debounce instances in the button/control path.

---
 rtl/controlador_botones.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/controlador_botones.sv
// Debounce controller and round-robin event arbiter for a bank of push buttons.
// All buttons share one sampling prescaler; debounced presses are queued as
// pending bits and offered one at a time over a valid/ready handshake.
//
// state  | meaning
// LIBRE  | no event offered; grants the next pending button, if any
// OFRECE | evento_valido high, evento_id stable until evento_listo
module controlador_botones #(
  parameter int NUM_BOTONES       = 4,
  parameter int CICLOS_MUESTREO   = 1000,
  parameter int MUESTRAS_ESTABLES = 4,
  localparam int IDW = $clog2(NUM_BOTONES)
) (
  input  logic                   reloj,
  input  logic                   reinicio,
  input  logic [NUM_BOTONES-1:0] botones,
  input  logic                   evento_listo,
  input  logic                   limpiar_desborde,
  output logic                   evento_valido,
  output logic [IDW-1:0]         evento_id,
  output logic [NUM_BOTONES-1:0] estado_botones,
  output logic                   desborde
);

  localparam int PW = $clog2(CICLOS_MUESTREO);
  localparam int CW = $clog2(MUESTRAS_ESTABLES);
  localparam logic [PW-1:0]  PRE_MAX = PW'(CICLOS_MUESTREO - 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(MUESTRAS_ESTABLES - 1);
  localparam logic [IDW-1:0] ID_MAX  = IDW'(NUM_BOTONES - 1);

  typedef enum logic {LIBRE, OFRECE} estado_t;

  logic [NUM_BOTONES-1:0]         sinc1_q, sinc_q;
  logic [PW-1:0]                  pre_q, pre_d;
  logic [NUM_BOTONES-1:0][CW-1:0] cnt_q, cnt_d;
  logic [NUM_BOTONES-1:0]         estado_q, estado_d;
  logic [NUM_BOTONES-1:0]         pend_q, pend_d;
  logic [NUM_BOTONES-1:0]         sube, limpia;
  logic                           tick;
  estado_t                        fsm_q, fsm_d;
  logic                           valido_q, valido_d;
  logic [IDW-1:0]                 id_q, id_d;
  logic [IDW-1:0]                 ptr_q, ptr_d;
  logic                           desb_q, desb_d;
  logic                           hallado;
  logic [IDW-1:0]                 idx_sel, pos;

  assign tick = (pre_q == PRE_MAX);

  // Prescaler wrap and per-button debounce counters; flags debounced rising edges.
  always_comb begin
    pre_d    = tick ? '0 : pre_q + 1'b1;
    cnt_d    = cnt_q;
    estado_d = estado_q;
    sube     = '0;
    if (tick) begin
      for (int i = 0; i < NUM_BOTONES; i++) begin
        if (sinc_q[i] == estado_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_MAX) begin
          estado_d[i] = ~estado_q[i];
          cnt_d[i]    = '0;
          sube[i]     = ~estado_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Round-robin scan: first pending bit at or above the pointer, wrapping.
  always_comb begin
    hallado = 1'b0;
    idx_sel = '0;
    pos     = '0;
    for (int k = 0; k < NUM_BOTONES; k++) begin
      pos = IDW'((int'(ptr_q) + k) % NUM_BOTONES);
      if (!hallado && pend_q[pos]) begin
        hallado = 1'b1;
        idx_sel = pos;
      end
    end
  end

  // Arbiter next state, pending queue and sticky overflow.
  always_comb begin
    fsm_d    = fsm_q;
    valido_d = valido_q;
    id_d     = id_q;
    ptr_d    = ptr_q;
    limpia   = '0;
    case (fsm_q)
      LIBRE: begin
        if (hallado) begin
          fsm_d           = OFRECE;
          valido_d        = 1'b1;
          id_d            = idx_sel;
          limpia[idx_sel] = 1'b1;
        end
      end
      OFRECE: begin
        if (evento_listo) begin
          fsm_d    = LIBRE;
          valido_d = 1'b0;
          ptr_d    = (id_q == ID_MAX) ? '0 : id_q + 1'b1;
        end
      end
      default: fsm_d = LIBRE;
    endcase
    // A press landing on the edge that grants the same bit is kept, not an overflow.
    pend_d = (pend_q & ~limpia) | sube;
    desb_d = (desb_q & ~limpiar_desborde) | (|(sube & pend_q & ~limpia));
  end

  // Synchroniser, prescaler and debounce registers.
  always_ff @(posedge reloj or negedge reinicio) begin
    if (!reinicio) begin
      sinc1_q  <= '0;
      sinc_q   <= '0;
      pre_q    <= '0;
      cnt_q    <= '0;
      estado_q <= '0;
    end else begin
      sinc1_q  <= botones;
      sinc_q   <= sinc1_q;
      pre_q    <= pre_d;
      cnt_q    <= cnt_d;
      estado_q <= estado_d;
    end
  end

  // Arbiter state register and handshake outputs.
  always_ff @(posedge reloj or negedge reinicio) begin
    if (!reinicio) begin
      fsm_q    <= LIBRE;
      valido_q <= 1'b0;
      id_q     <= '0;
      ptr_q    <= '0;
      pend_q   <= '0;
      desb_q   <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      valido_q <= valido_d;
      id_q     <= id_d;
      ptr_q    <= ptr_d;
      pend_q   <= pend_d;
      desb_q   <= desb_d;
    end
  end

  assign evento_valido  = valido_q;
  assign evento_id      = id_q;
  assign estado_botones = estado_q;
  assign desborde       = desb_q;

endmodule
